// File: rtl/trap_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_seq_pkg: CSR addresses, opcodes, cause codes, bit indices, states.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package trap_seq_pkg;

    localparam logic [11:0] C_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] C_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] C_CSR_MEPC    = 12'h341;
    localparam logic [11:0] C_CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] C_INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] C_INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] C_INSTR_MRET   = 32'h3020_0073;

    localparam logic [31:0] C_CAUSE_MEI    = 32'h8000_000B;
    localparam logic [31:0] C_CAUSE_MTI    = 32'h8000_0007;
    localparam logic [31:0] C_CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] C_CAUSE_EBREAK = 32'd3;

    localparam int C_MSTATUS_MIE  = 3;
    localparam int C_MSTATUS_MPIE = 7;
    localparam int C_MSTATUS_MPP  = 11;
    localparam int C_MIE_MEIE     = 11;
    localparam int C_MIE_MTIE     = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EPC    = 3'd1;
    localparam logic [2:0] ST_CAUSE  = 3'd2;
    localparam logic [2:0] ST_STATUS = 3'd3;
    localparam logic [2:0] ST_REDIR  = 3'd4;
    localparam logic [2:0] ST_MSTAT  = 3'd5;
    localparam logic [2:0] ST_MREDIR = 3'd6;

endpackage
`default_nettype wire

// File: rtl/trap_seq_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_seq_detect: prioritised trap/MRET decode at the commit boundary.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module trap_seq_detect
    import trap_seq_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic        i_irq_ext,
    input  logic        i_irq_timer,
    input  logic [31:0] i_mstatus,
    input  logic [31:0] i_mie,
    output logic        o_take,
    output logic        o_is_mret,
    output logic [31:0] o_cause
);

    logic w_mei;
    logic w_mti;
    logic w_unused;

    assign w_mei = i_irq_ext   & i_mie[C_MIE_MEIE] & i_mstatus[C_MSTATUS_MIE];
    assign w_mti = i_irq_timer & i_mie[C_MIE_MTIE] & i_mstatus[C_MSTATUS_MIE];
    assign w_unused = ^{i_mstatus[31:4], i_mstatus[2:0], i_mie[31:12], i_mie[10:8], i_mie[6:0]};

    always_comb begin
        o_take    = 1'b0;
        o_is_mret = 1'b0;
        o_cause   = '0;
        if (w_mei) begin
            o_take  = 1'b1;
            o_cause = C_CAUSE_MEI;
        end else if (w_mti) begin
            o_take  = 1'b1;
            o_cause = C_CAUSE_MTI;
        end else if (i_instr == C_INSTR_ECALL) begin
            o_take  = 1'b1;
            o_cause = C_CAUSE_ECALL;
        end else if (i_instr == C_INSTR_EBREAK) begin
            o_take  = 1'b1;
            o_cause = C_CAUSE_EBREAK;
        end else if (i_instr == C_INSTR_MRET) begin
            o_is_mret = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_seq: M-mode trap/MRET sequencer, CSR write-port arbiter, PC redirect.|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module trap_seq
    import trap_seq_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   pc,
    input  logic              irq_ext,
    input  logic              irq_timer,
    input  logic [XLEN-1:0]   csr_mstatus,
    input  logic [XLEN-1:0]   csr_mie,
    input  logic [XLEN-1:0]   csr_mtvec,
    input  logic [XLEN-1:0]   csr_mepc,
    input  logic              core_csr_we,
    input  logic [CSR_AW-1:0] core_csr_addr,
    input  logic [XLEN-1:0]   core_csr_wdata,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              stall,
    output logic              squash,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   pc_target
);

    logic [2:0]        r_state;
    logic [XLEN-1:0]   r_pc_lat;
    logic [XLEN-1:0]   r_cause_lat;

    logic              w_take;
    logic              w_is_mret;
    logic [31:0]       w_cause;
    logic              w_trig;
    logic [2:0]        w_next;
    logic              w_we;
    logic [CSR_AW-1:0] w_addr;
    logic [XLEN-1:0]   w_wdata;
    logic              w_stall;
    logic              w_squash;
    logic              w_redir;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_mstatus_trap;
    logic [XLEN-1:0]   w_mstatus_ret;
    logic              w_unused;

    trap_seq_detect u_detect (
        .i_instr     (instr),
        .i_irq_ext   (irq_ext),
        .i_irq_timer (irq_timer),
        .i_mstatus   (csr_mstatus),
        .i_mie       (csr_mie),
        .o_take      (w_take),
        .o_is_mret   (w_is_mret),
        .o_cause     (w_cause)
    );

    assign w_trig   = instr_valid & (w_take | w_is_mret);
    assign w_unused = ^csr_mtvec[1:0];

    // Read-modify-write of the live mstatus value seen in the write cycle
    always_comb begin
        w_mstatus_trap                                      = csr_mstatus;
        w_mstatus_trap[C_MSTATUS_MPIE]                      = csr_mstatus[C_MSTATUS_MIE];
        w_mstatus_trap[C_MSTATUS_MIE]                       = 1'b0;
        w_mstatus_trap[C_MSTATUS_MPP+1:C_MSTATUS_MPP]       = 2'b11;
        w_mstatus_ret                                       = csr_mstatus;
        w_mstatus_ret[C_MSTATUS_MIE]                        = csr_mstatus[C_MSTATUS_MPIE];
        w_mstatus_ret[C_MSTATUS_MPIE]                       = 1'b1;
        w_mstatus_ret[C_MSTATUS_MPP+1:C_MSTATUS_MPP]        = 2'b11;
    end

    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        w_stall  = 1'b0;
        w_squash = 1'b0;
        w_redir  = 1'b0;
        w_target = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_stall  = 1'b1;
                    w_squash = 1'b1;
                    w_next   = w_take ? ST_EPC : ST_MSTAT;
                end else if (core_csr_we) begin
                    w_we    = 1'b1;
                    w_addr  = core_csr_addr;
                    w_wdata = core_csr_wdata;
                end
            end
            ST_EPC: begin
                w_we    = 1'b1;
                w_addr  = C_CSR_MEPC;
                w_wdata = r_pc_lat;
                w_stall = 1'b1;
                w_next  = ST_CAUSE;
            end
            ST_CAUSE: begin
                w_we    = 1'b1;
                w_addr  = C_CSR_MCAUSE;
                w_wdata = r_cause_lat;
                w_stall = 1'b1;
                w_next  = ST_STATUS;
            end
            ST_STATUS: begin
                w_we    = 1'b1;
                w_addr  = C_CSR_MSTATUS;
                w_wdata = w_mstatus_trap;
                w_stall = 1'b1;
                w_next  = ST_REDIR;
            end
            ST_REDIR: begin
                w_redir  = 1'b1;
                w_target = {csr_mtvec[XLEN-1:2], 2'b00};
                w_next   = ST_IDLE;
            end
            ST_MSTAT: begin
                w_we    = 1'b1;
                w_addr  = C_CSR_MSTATUS;
                w_wdata = w_mstatus_ret;
                w_stall = 1'b1;
                w_next  = ST_MREDIR;
            end
            ST_MREDIR: begin
                w_redir  = 1'b1;
                w_target = csr_mepc;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_pc_lat    <= '0;
            r_cause_lat <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_trig) begin
                r_pc_lat    <= pc;
                r_cause_lat <= w_take ? w_cause : '0;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted
    assign csr_we      = rstn & w_we;
    assign csr_addr    = rstn ? w_addr   : '0;
    assign csr_wdata   = rstn ? w_wdata  : '0;
    assign stall       = rstn & w_stall;
    assign squash      = rstn & w_squash;
    assign pc_redirect = rstn & w_redir;
    assign pc_target   = rstn ? w_target : '0;

endmodule
`default_nettype wire
